// File: rtl/i2s_mic_pkg.sv
// Shared types and sizing helpers for the I2S microphone receiver.
package i2s_mic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        RUN
    } i2s_state_t;

    localparam int DEF_CLK_DIV      = 16;
    localparam int DEF_SLOT_BITS    = 32;
    localparam int DEF_SAMPLE_WIDTH = 18;

    function automatic int div_cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int bit_cnt_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    function automatic int skip_cnt_width(input int skip_frames);
        return (skip_frames > 0) ? $clog2(skip_frames + 1) : 1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock / word select generator: divider and bit counters plus the
// strobes the receiver needs to capture bits and count frames.
module i2s_bclk_gen
    import i2s_mic_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int SLOT_BITS = DEF_SLOT_BITS
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                run,
    output logic                                mic_clk,
    output logic                                mic_ws,
    output logic                                capture,
    output logic                                frame_end,
    output logic [bit_cnt_width(SLOT_BITS)-1:0] bit_cnt
);

    localparam int DW = div_cnt_width(CLK_DIV);
    localparam int BW = bit_cnt_width(SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF     = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_PRE_RISE = DW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN     = BW'(SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic          div_wrap;

    assign div_wrap  = run && (div_cnt == DIV_LAST);
    assign capture   = run && (div_cnt == DIV_PRE_RISE);
    assign frame_end = div_wrap && (bit_cnt == BIT_LAST);

    // NOTE: reset is synchronous, so it is simply the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            mic_clk <= 1'b0;
            mic_ws  <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end
            // Registered from the current counts, so both pins lag the counters by one clk.
            mic_clk <= (div_cnt >= DIV_HALF);
            mic_ws  <= (bit_cnt >= SLOT_LEN);
        end
    end

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: frame-skip FSM, slot capture shift register and
// a single-entry valid/ready output register with sticky overrun.
module i2s_mic_rx
    import i2s_mic_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int SLOT_BITS    = DEF_SLOT_BITS,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int CHANNEL      = 0,
    parameter int SKIP_FRAMES  = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    output logic                           mic_clk,
    output logic                           mic_ws,
    input  logic                           mic_dout,
    output logic signed [SAMPLE_WIDTH-1:0] sample_data,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           overrun,
    input  logic                           overrun_clr
);

    localparam int BW  = bit_cnt_width(SLOT_BITS);
    localparam int SKW = skip_cnt_width(SKIP_FRAMES);

    localparam logic [BW-1:0]  SLOT_LEN  = BW'(SLOT_BITS);
    localparam logic [BW-1:0]  K_LAST    = BW'(SAMPLE_WIDTH);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
    localparam logic           CHAN_SEL  = (CHANNEL != 0);

    i2s_state_t state, state_next;

    logic                    run;
    logic                    capture;
    logic                    frame_end;
    logic [BW-1:0]           bit_cnt;
    logic [BW-1:0]           slot_idx;
    logic                    in_right;
    logic                    capture_bit;
    logic [SKW-1:0]          skip_cnt;
    logic [SAMPLE_WIDTH-1:0] shift_reg;
    logic                    done;

    assign run = enable && (state != IDLE);

    i2s_bclk_gen #(
        .CLK_DIV   (CLK_DIV),
        .SLOT_BITS (SLOT_BITS)
    ) u_bclk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .mic_clk   (mic_clk),
        .mic_ws    (mic_ws),
        .capture   (capture),
        .frame_end (frame_end),
        .bit_cnt   (bit_cnt)
    );

    // Slot index k; the MSB sits at k=1 because of the I2S one-bit delay.
    assign in_right    = (bit_cnt >= SLOT_LEN);
    assign slot_idx    = in_right ? bit_cnt - SLOT_LEN : bit_cnt;
    assign capture_bit = capture && (state == RUN) && (in_right == CHAN_SEL)
                         && (slot_idx != '0) && (slot_idx <= K_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is assigned before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = (SKIP_FRAMES == 0) ? RUN : SKIP;
            SKIP:    if (frame_end && (skip_cnt == SKIP_LAST)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || (state == IDLE)) begin
            skip_cnt <= '0;
        end else if ((state == SKIP) && frame_end) begin
            skip_cnt <= skip_cnt + 1'b1;
        end
    end

    // Clearing in IDLE drops any partially shifted sample across an enable cycle.
    always_ff @(posedge clk) begin
        if (!reset_n || (state == IDLE)) begin
            shift_reg <= '0;
            done      <= 1'b0;
        end else begin
            done <= capture_bit && (slot_idx == K_LAST);
            if (capture_bit) begin
                shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], mic_dout};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (done) begin
                sample_data  <= $signed(shift_reg);
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            // A new sample replacing an unaccepted one wins over a same-cycle clear.
            if (done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: default left-channel 18-bit instance and a right-channel
// 24-bit instance, each fed by an I2S mic model and checked against a timeline model.
module tb_i2s_mic_rx;

    localparam int CD    = 16;
    localparam int S     = 32;
    localparam int F     = 2 * S * CD;
    localparam int SKIPF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        en0, en1, ready0, ready1, clr0, clr1;
    logic        mic_clk0, mic_ws0, mic_clk1, mic_ws1;
    logic        dout0 = 1'b0, dout1 = 1'b0;
    logic [17:0] data0;
    logic [23:0] data1;
    logic        valid0, valid1, ovr0, ovr1;
    logic [17:0] left0, right0;
    logic [23:0] left1, right1;

    int total_cnt = 0;
    int pass_cnt  = 0;
    bit cmp_on    = 1'b0;

    i2s_mic_rx dut0 (
        .clk (clk), .reset_n (reset_n), .enable (en0),
        .mic_clk (mic_clk0), .mic_ws (mic_ws0), .mic_dout (dout0),
        .sample_data (data0), .sample_valid (valid0), .sample_ready (ready0),
        .overrun (ovr0), .overrun_clr (clr0)
    );

    i2s_mic_rx #(.SAMPLE_WIDTH (24), .CHANNEL (1)) dut1 (
        .clk (clk), .reset_n (reset_n), .enable (en1),
        .mic_clk (mic_clk1), .mic_ws (mic_ws1), .mic_dout (dout1),
        .sample_data (data1), .sample_valid (valid1), .sample_ready (ready1),
        .overrun (ovr1), .overrun_clr (clr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Mic models: shift a word out MSB first from k=1, changing data on mic_clk falling edges.
    int   k0, k1;
    logic ws_last0, ws_last1;
    logic [17:0] word0;
    logic [23:0] word1;

    always @(negedge mic_clk0 or negedge en0) begin
        if (!en0) begin
            k0 = 0; ws_last0 = 1'b0; dout0 = 1'b0;
        end else begin
            if (mic_ws0 != ws_last0) k0 = 0; else k0 = k0 + 1;
            ws_last0 = mic_ws0;
            word0 = mic_ws0 ? right0 : left0;
            dout0 = (k0 >= 1 && k0 <= 18) ? word0[18-k0] : 1'b1;
        end
    end

    always @(negedge mic_clk1 or negedge en1) begin
        if (!en1) begin
            k1 = 0; ws_last1 = 1'b0; dout1 = 1'b0;
        end else begin
            if (mic_ws1 != ws_last1) k1 = 0; else k1 = k1 + 1;
            ws_last1 = mic_ws1;
            word1 = mic_ws1 ? right1 : left1;
            dout1 = (k1 >= 1 && k1 <= 24) ? word1[24-k1] : 1'b1;
        end
    end

    // Timeline model: n = clk edges since enable was sampled high.
    function automatic logic exp_clk(input bit act, input int n);
        return act && (n >= 1) && (((n - 1) % CD) >= CD / 2);
    endfunction

    function automatic logic exp_ws(input bit act, input int n);
        return act && (n >= 1) && ((((n - 1) / CD) % (2 * S)) >= S);
    endfunction

    // Clock edge (within a frame) where the LSB of the selected slot is sampled.
    localparam int LSB_EDGE0 = (0 * S + 18) * CD + CD / 2;
    localparam int LSB_EDGE1 = (1 * S + 24) * CD + CD / 2;

    bit          act0, act1, pend0, pend1, load0, load1, hs0, hs1;
    int          n0, n1;
    logic        mv0, mv1, mo0, mo1;
    logic [17:0] md0;
    logic [23:0] md1;

    always @(posedge clk) begin
        if (!reset_n) begin
            act0 = 0; n0 = 0; pend0 = 0; mv0 = 0; md0 = '0; mo0 = 0;
            act1 = 0; n1 = 0; pend1 = 0; mv1 = 0; md1 = '0; mo1 = 0;
        end else begin
            load0 = pend0; pend0 = 0;
            if (!en0) act0 = 0;
            else if (!act0) begin act0 = 1; n0 = 0; end
            else n0++;
            if (act0 && n0 >= SKIPF * F && (n0 % F) == LSB_EDGE0) pend0 = 1;
            hs0 = mv0 && ready0;
            if (load0 && mv0 && !hs0) mo0 = 1; else if (clr0) mo0 = 0;
            if (load0) begin mv0 = 1; md0 = left0; end else if (hs0) mv0 = 0;

            load1 = pend1; pend1 = 0;
            if (!en1) act1 = 0;
            else if (!act1) begin act1 = 1; n1 = 0; end
            else n1++;
            if (act1 && n1 >= SKIPF * F && (n1 % F) == LSB_EDGE1) pend1 = 1;
            hs1 = mv1 && ready1;
            if (load1 && mv1 && !hs1) mo1 = 1; else if (clr1) mo1 = 0;
            if (load1) begin mv1 = 1; md1 = right1; end else if (hs1) mv1 = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("mic_clk0", mic_clk0, exp_clk(act0, n0));
            check("mic_ws0",  mic_ws0,  exp_ws(act0, n0));
            check("valid0",   valid0,   mv0);
            check("data0",    data0,    md0);
            check("overrun0", ovr0,     mo0);
            check("mic_clk1", mic_clk1, exp_clk(act1, n1));
            check("mic_ws1",  mic_ws1,  exp_ws(act1, n1));
            check("valid1",   valid1,   mv1);
            check("data1",    data1,    md1);
            check("overrun1", ovr1,     mo1);
        end
    end

    task automatic wait_valid0(input int budget, output int n_at);
        bit seen = 0;
        n_at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid0) begin seen = 1; n_at = n0; end
        end
        if (!seen) check("timeout_valid0", 32'd0, 32'd1);
    endtask

    task automatic wait_valid1(input int budget, output int n_at);
        bit seen = 0;
        n_at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (valid1) begin seen = 1; n_at = n1; end
        end
        if (!seen) check("timeout_valid1", 32'd0, 32'd1);
    endtask

    task automatic wait_phase0(input int phase);
        bit seen = 0;
        for (int i = 0; i < 2 * F && !seen; i++) begin
            @(negedge clk);
            if ((n0 % F) == phase) seen = 1;
        end
        if (!seen) check("timeout_phase0", 32'd0, 32'd1);
    endtask

    initial begin
        int n_at, hi, lo, cnt, t_rise, t_fall;
        bit seen;
        logic prev;

        reset_n = 0; en0 = 0; en1 = 0; ready0 = 1; ready1 = 1; clr0 = 0; clr1 = 0;
        left0 = 18'h2A5C3; right0 = 18'h15555;
        left1 = 24'h5A5A5A; right1 = 24'h800001;
        @(negedge clk);
        cmp_on = 1;
        repeat (4) @(negedge clk);
        reset_n = 1;

        // Idle after reset: mic_clk static, all outputs at reset values.
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (mic_clk0 !== 1'b0 || mic_clk1 !== 1'b0) cnt++;
        end
        check("idle_mic_clk_active", cnt, 0);
        check("reset_valid", valid0, 1'b0);
        check("reset_data", data0, 18'h0);
        check("reset_overrun", ovr0, 1'b0);
        check("reset_ws", mic_ws0, 1'b0);

        // Clock shape.
        en0 = 1; en1 = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mic_clk0) seen = 1;
        end
        check("first_rise_edge", n0, 9);
        hi = 0;
        while (mic_clk0 && hi < 40) begin hi++; @(negedge clk); end
        lo = 0;
        while (!mic_clk0 && lo < 40) begin lo++; @(negedge clk); end
        check("mic_clk_high_len", hi, 8);
        check("mic_clk_low_len", lo, 8);

        t_rise = -1; t_fall = -1; prev = mic_clk0;
        for (int i = 0; i < 2 * F && t_fall < 0; i++) begin
            @(negedge clk);
            if (t_rise < 0 && mic_ws0) begin
                t_rise = n0;
                check("ws_rise_on_clk_fall", {prev, mic_clk0}, 2'b10);
            end else if (t_rise >= 0 && !mic_ws0) begin
                t_fall = n0;
                check("ws_fall_on_clk_fall", {prev, mic_clk0}, 2'b10);
            end
            prev = mic_clk0;
        end
        check("ws_first_rise", t_rise, 513);
        check("ws_half_period", t_fall - t_rise, 512);

        // Capture after four skipped frames.
        wait_valid0(6000, n_at);
        check("first_sample_edge0", n_at, 4393);
        check("first_sample_data0", data0, 18'h2A5C3);
        wait_valid1(1000, n_at);
        check("first_sample_edge1", n_at, 5001);
        check("first_sample_data1", data1, 24'h800001);
        check("sample1_negative", data1[23], 1'b1);

        cnt = 0;
        repeat (2 * S * CD * 2) begin
            @(negedge clk);
            if (valid0) cnt++;
        end
        check("one_pulse_per_frame", cnt, 2);

        // Backpressure across two completions.
        ready0 = 0;
        wait_valid0(F + 100, n_at);
        check("held_sample_edge", n_at, 7465);
        check("held_sample_data", data0, 18'h2A5C3);
        wait_phase0(800);
        left0 = 18'h12345;
        seen = 0;
        for (int i = 0; i < F + 100 && !seen; i++) begin
            @(negedge clk);
            if (ovr0) seen = 1;
        end
        check("overrun_edge", n0, 8489);
        check("overrun_data", data0, 18'h12345);
        check("overrun_valid", valid0, 1'b1);
        ready0 = 1;
        @(negedge clk);
        check("valid_after_accept", valid0, 1'b0);
        ready0 = 0; clr0 = 1;
        @(negedge clk);
        clr0 = 0;
        check("overrun_cleared", ovr0, 1'b0);

        // Clear on the same cycle as a new overrun: set wins.
        wait_valid0(F + 100, n_at);
        wait_phase0(LSB_EDGE0);
        clr0 = 1;
        @(negedge clk);
        clr0 = 0;
        check("overrun_set_beats_clr", ovr0, 1'b1);
        @(negedge clk);
        check("overrun_still_set", ovr0, 1'b1);
        ready0 = 1; clr0 = 1;
        @(negedge clk);
        clr0 = 0;
        check("overrun_final_clear", ovr0, 1'b0);

        // Enable drop at k=9 of the left slot.
        wait_phase0(9 * CD);
        en0 = 0;
        hi = 0; cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mic_clk0) hi++;
            if (valid0) cnt++;
        end
        check("idle_mic_clk_high", hi, 0);
        check("idle_no_partial", cnt, 0);
        en0 = 1;
        wait_valid0(6000, n_at);
        check("reenable_sample_edge", n_at, 4393);
        check("reenable_sample_data", data0, 18'h12345);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
